// File: rtl/mc_ctrl_pkg.sv
// Purpose: shared constants, state encoding and opcode classification for the
//          multicycle MIPS control FSM.
// Contents: opcode constants, state_e, op_cls_e, alu_op / alu_src_b / pc_source
//           codes, op_class() helper.
package mc_ctrl_pkg;

    localparam int unsigned OPCODE_W = 6;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPCODE_W-1:0] OP_LH    = 6'h21;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_LHU   = 6'h25;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        ST_RESET,
        ST_FETCH,
        ST_DECODE,
        ST_MEMADDR,
        ST_MEMRD,
        ST_MEMWB,
        ST_MEMWR,
        ST_REXEC,
        ST_RWB,
        ST_IEXEC,
        ST_IWB,
        ST_BRANCH,
        ST_FAULT
    } state_e;

    // Instruction class latched in DECODE; later states never see the live opcode.
    typedef enum logic [2:0] {
        CLS_OTHER,
        CLS_LW,
        CLS_LH,
        CLS_LHU,
        CLS_SW,
        CLS_ADDI,
        CLS_ANDI,
        CLS_ORI
    } op_cls_e;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_ADDI  = 3'd3;
    localparam logic [2:0] ALU_AND   = 3'd4;
    localparam logic [2:0] ALU_OR    = 3'd5;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;

    function automatic op_cls_e op_class(input logic [OPCODE_W-1:0] op);
        op_cls_e cls;
        cls = CLS_OTHER;
        case (op)
            OP_LW:   cls = CLS_LW;
            OP_LH:   cls = CLS_LH;
            OP_LHU:  cls = CLS_LHU;
            OP_SW:   cls = CLS_SW;
            OP_ADDI: cls = CLS_ADDI;
            OP_ANDI: cls = CLS_ANDI;
            OP_ORI:  cls = CLS_ORI;
            default: cls = CLS_OTHER;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Purpose: counts consecutive stalled cycles of a memory access and flags when
//          the stall reaches MEM_TIMEOUT (0 disables the check).
// Ports: clk, rst_n (sync, active-low), in_mem_state (FSM is in a memory state),
//        mem_ready (access completes this cycle), expired (combinational: this
//        stalled cycle is the MEM_TIMEOUT-th one).
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_mem_state,
    input  logic mem_ready,
    output logic expired
);

    // Counter holds the number of stalled cycles already seen, so it only has
    // to reach MEM_TIMEOUT-1 before the FSM leaves the memory state.
    localparam int unsigned CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int unsigned LIMIT = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_stall;

    assign w_stall = in_mem_state && !mem_ready;

    // Any cycle that is not a stall (completion, or outside a memory state) clears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_stall) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // mem_ready in the limit cycle wins because w_stall is then low.
    assign expired = (MEM_TIMEOUT != 0) && w_stall && (r_cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/multicycle_control.sv
// Purpose: multicycle control FSM for the shared-memory MIPS datapath; drives
//          every datapath mux/enable from the IR opcode with a mem_ready
//          handshake and a bounded memory wait.
// Ports: clk, rst_n (sync, active-low), opcode (IR[31:26], used in DECODE),
//        mem_ready; datapath controls pc_write, pc_write_cond, ior_d, ir_write,
//        mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
//        alu_src_b, pc_source, alu_op, load_half, load_half_unsigned; retire
//        pulse; sticky fault flags illegal_op, mem_timeout.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W     = 3,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               ior_d,
    output logic               ir_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_source,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               load_half,
    output logic               load_half_unsigned,
    output logic               retire,
    output logic               illegal_op,
    output logic               mem_timeout
);

    state_e  r_state;
    state_e  w_next;
    op_cls_e r_cls;
    logic    r_illegal;
    logic    r_timeout;
    logic    w_in_mem;
    logic    w_expired;
    logic    w_set_illegal;

    assign w_in_mem = (r_state == ST_FETCH) || (r_state == ST_MEMRD) || (r_state == ST_MEMWR);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_mem_state (w_in_mem),
        .mem_ready    (mem_ready),
        .expired      (w_expired)
    );

    // State, latched opcode class and sticky fault flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_RESET;
            r_cls     <= CLS_OTHER;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_cls <= op_class(opcode);
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_expired) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign illegal_op  = r_illegal;
    assign mem_timeout = r_timeout;

    // Next state and Moore outputs; pc_write/ir_write/MEMWR retire are Mealy on mem_ready.
    always_comb begin
        w_next             = r_state;
        w_set_illegal      = 1'b0;
        pc_write           = 1'b0;
        pc_write_cond      = 1'b0;
        ior_d              = 1'b0;
        ir_write           = 1'b0;
        mem_read           = 1'b0;
        mem_write          = 1'b0;
        mem_to_reg         = 1'b0;
        reg_dst            = 1'b0;
        reg_write          = 1'b0;
        alu_src_a          = 1'b0;
        alu_src_b          = SRCB_B;
        pc_source          = PCSRC_ALU;
        alu_op             = ALUOP_W'(ALU_ADD);
        load_half          = 1'b0;
        load_half_unsigned = 1'b0;
        retire             = 1'b0;

        case (r_state)
            ST_RESET: begin
                w_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = ST_DECODE;
                end else if (w_expired) begin
                    w_next = ST_FAULT;
                end
            end
            ST_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                case (opcode)
                    OP_RTYPE:                    w_next = ST_REXEC;
                    OP_LW, OP_LH, OP_LHU, OP_SW: w_next = ST_MEMADDR;
                    OP_ADDI, OP_ANDI, OP_ORI:    w_next = ST_IEXEC;
                    OP_BEQ:                      w_next = ST_BRANCH;
                    default: begin
                        w_next        = ST_FAULT;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            ST_MEMADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                w_next    = (r_cls == CLS_SW) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                mem_read = 1'b1;
                ior_d    = 1'b1;
                if (mem_ready) begin
                    w_next = ST_MEMWB;
                end else if (w_expired) begin
                    w_next = ST_FAULT;
                end
            end
            ST_MEMWR: begin
                mem_write = 1'b1;
                ior_d     = 1'b1;
                if (mem_ready) begin
                    retire = 1'b1;
                    w_next = ST_FETCH;
                end else if (w_expired) begin
                    w_next = ST_FAULT;
                end
            end
            ST_MEMWB: begin
                reg_write          = 1'b1;
                mem_to_reg         = 1'b1;
                load_half          = (r_cls == CLS_LH);
                load_half_unsigned = (r_cls == CLS_LHU);
                retire             = 1'b1;
                w_next             = ST_FETCH;
            end
            ST_REXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_B;
                alu_op    = ALUOP_W'(ALU_FUNCT);
                w_next    = ST_RWB;
            end
            ST_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                w_next    = ST_FETCH;
            end
            ST_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                case (r_cls)
                    CLS_ANDI: alu_op = ALUOP_W'(ALU_AND);
                    CLS_ORI:  alu_op = ALUOP_W'(ALU_OR);
                    default:  alu_op = ALUOP_W'(ALU_ADDI);
                endcase
                w_next = ST_IWB;
            end
            ST_IWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                w_next    = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_W'(ALU_SUB);
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                retire        = 1'b1;
                w_next        = ST_FETCH;
            end
            ST_FAULT: begin
                w_next = ST_FAULT;
            end
            default: begin
                w_next = ST_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Purpose: directed self-checking bench for multicycle_control (MEM_TIMEOUT=4).
// Each step drives inputs just after a rising edge, compares the full output
// vector against a hand-derived table entry, then advances one clock.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, ior_d, ir_write;
    logic       mem_read, mem_write, mem_to_reg, reg_dst, reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic       load_half, load_half_unsigned, retire, illegal_op, mem_timeout;

    int n_cmp;
    int n_bad;

    localparam int T_RESET = 0, T_FETCH = 1, T_DECODE = 2, T_MEMADDR = 3,
                   T_MEMRD = 4, T_MEMWB = 5, T_MEMWR = 6, T_REXEC = 7,
                   T_RWB = 8, T_IEXEC = 9, T_IWB = 10, T_BRANCH = 11, T_FAULT = 12;

    localparam logic [5:0] JUNK = 6'h3F;

    multicycle_control #(
        .ALUOP_W     (3),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .opcode             (opcode),
        .mem_ready          (mem_ready),
        .pc_write           (pc_write),
        .pc_write_cond      (pc_write_cond),
        .ior_d              (ior_d),
        .ir_write           (ir_write),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .mem_to_reg         (mem_to_reg),
        .reg_dst            (reg_dst),
        .reg_write          (reg_write),
        .alu_src_a          (alu_src_a),
        .alu_src_b          (alu_src_b),
        .pc_source          (pc_source),
        .alu_op             (alu_op),
        .load_half          (load_half),
        .load_half_unsigned (load_half_unsigned),
        .retire             (retire),
        .illegal_op         (illegal_op),
        .mem_timeout        (mem_timeout)
    );

    always #5 clk = ~clk;

    logic [21:0] obs;
    assign obs = {pc_write, pc_write_cond, ior_d, ir_write, mem_read, mem_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
                  alu_op, load_half, load_half_unsigned, retire, illegal_op, mem_timeout};

    // Expected output vector per state; sub = IEXEC alu_op or MEMWB load kind (1 lh, 2 lhu).
    function automatic logic [21:0] E(input int st, input logic rdy, input int sub,
                                      input logic [1:0] fl);
        logic pw, pwc, iord, irw, mr, mw, m2r, rdst, rw, asa, lh, lhu, ret;
        logic [1:0] asb, ps;
        logic [2:0] aop;
        {pw, pwc, iord, irw, mr, mw, m2r, rdst, rw, asa, lh, lhu, ret} = '0;
        asb = 2'd0; ps = 2'd0; aop = 3'd0;
        case (st)
            T_FETCH:   begin mr = 1'b1; asb = 2'd1; irw = rdy; pw = rdy; end
            T_DECODE:  begin asb = 2'd3; end
            T_MEMADDR: begin asa = 1'b1; asb = 2'd2; end
            T_MEMRD:   begin mr = 1'b1; iord = 1'b1; end
            T_MEMWR:   begin mw = 1'b1; iord = 1'b1; ret = rdy; end
            T_MEMWB:   begin rw = 1'b1; m2r = 1'b1; lh = (sub == 1); lhu = (sub == 2); ret = 1'b1; end
            T_REXEC:   begin asa = 1'b1; aop = 3'd2; end
            T_RWB:     begin rw = 1'b1; rdst = 1'b1; ret = 1'b1; end
            T_IEXEC:   begin asa = 1'b1; asb = 2'd2; aop = 3'(sub); end
            T_IWB:     begin rw = 1'b1; ret = 1'b1; end
            T_BRANCH:  begin asa = 1'b1; aop = 3'd1; pwc = 1'b1; ps = 2'd1; ret = 1'b1; end
            default:   ;
        endcase
        return {pw, pwc, iord, irw, mr, mw, m2r, rdst, rw, asa, asb, ps, aop, lh, lhu, ret, fl};
    endfunction

    // One clock step: drive, compare at +2 after the edge, then advance to the next edge +1.
    task automatic cyc(input string tag, input logic rstn, input logic rdy,
                       input logic [5:0] op, input logic [21:0] exp);
        rst_n     = rstn;
        mem_ready = rdy;
        opcode    = op;
        #1;
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input string t, input logic [5:0] op);
        cyc({t, "_fetch"}, 1'b1, 1'b1, JUNK, E(T_FETCH, 1'b1, 0, 2'b00));
        cyc({t, "_decode"}, 1'b1, 1'b1, op, E(T_DECODE, 1'b1, 0, 2'b00));
    endtask

    task automatic run_load(input string t, input logic [5:0] op, input int kind, input int waits);
        fetch_decode(t, op);
        cyc({t, "_memaddr"}, 1'b1, 1'b1, JUNK, E(T_MEMADDR, 1'b1, 0, 2'b00));
        for (int i = 0; i < waits; i++)
            cyc({t, "_memrd_wait"}, 1'b1, 1'b0, JUNK, E(T_MEMRD, 1'b0, 0, 2'b00));
        cyc({t, "_memrd"}, 1'b1, 1'b1, JUNK, E(T_MEMRD, 1'b1, 0, 2'b00));
        cyc({t, "_memwb"}, 1'b1, 1'b1, JUNK, E(T_MEMWB, 1'b1, kind, 2'b00));
    endtask

    task automatic run_imm(input string t, input logic [5:0] op, input int aop);
        fetch_decode(t, op);
        cyc({t, "_iexec"}, 1'b1, 1'b1, JUNK, E(T_IEXEC, 1'b1, aop, 2'b00));
        cyc({t, "_iwb"}, 1'b1, 1'b1, JUNK, E(T_IWB, 1'b1, 0, 2'b00));
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        opcode    = JUNK;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, with mem_ready high to expose any Mealy leakage.
        cyc("reset", 1'b1, 1'b1, JUNK, E(T_RESET, 1'b1, 0, 2'b00));

        // R-type: FETCH, DECODE, REXEC, RWB (retire in cycle 4).
        fetch_decode("rtype", 6'h00);
        cyc("rtype_rexec", 1'b1, 1'b1, JUNK, E(T_REXEC, 1'b1, 0, 2'b00));
        cyc("rtype_rwb", 1'b1, 1'b1, JUNK, E(T_RWB, 1'b1, 0, 2'b00));

        // Back-to-back zero-wait instructions.
        run_load("lw", 6'h23, 0, 0);
        run_load("lh", 6'h21, 1, 0);
        run_load("lhu", 6'h25, 2, 0);
        fetch_decode("sw", 6'h2B);
        cyc("sw_memaddr", 1'b1, 1'b1, JUNK, E(T_MEMADDR, 1'b1, 0, 2'b00));
        cyc("sw_memwr", 1'b1, 1'b1, JUNK, E(T_MEMWR, 1'b1, 0, 2'b00));
        fetch_decode("beq", 6'h04);
        cyc("beq_branch", 1'b1, 1'b1, JUNK, E(T_BRANCH, 1'b1, 0, 2'b00));
        run_imm("andi", 6'h0C, 4);
        run_imm("ori", 6'h0D, 5);
        run_imm("addi", 6'h08, 3);

        // lw with three memory wait cycles in MEMRD: 8 cycles, no fault.
        run_load("lw_wait", 6'h23, 0, 3);

        // Fetch stalls 3 cycles, mem_ready arrives in the 4th: completes, no fault.
        for (int i = 0; i < 3; i++)
            cyc("edge_fetch_wait", 1'b1, 1'b0, JUNK, E(T_FETCH, 1'b0, 0, 2'b00));
        cyc("edge_fetch_ready", 1'b1, 1'b1, JUNK, E(T_FETCH, 1'b1, 0, 2'b00));
        cyc("edge_decode", 1'b1, 1'b1, 6'h04, E(T_DECODE, 1'b1, 0, 2'b00));
        cyc("edge_branch", 1'b1, 1'b1, JUNK, E(T_BRANCH, 1'b1, 0, 2'b00));

        // Fetch stuck for 4 wait cycles: FAULT with sticky mem_timeout.
        for (int i = 0; i < 4; i++)
            cyc("to_fetch_wait", 1'b1, 1'b0, JUNK, E(T_FETCH, 1'b0, 0, 2'b00));
        cyc("to_fault", 1'b1, 1'b1, JUNK, E(T_FAULT, 1'b1, 0, 2'b01));
        cyc("to_sticky", 1'b1, 1'b0, 6'h00, E(T_FAULT, 1'b0, 0, 2'b01));
        cyc("to_rst_edge", 1'b0, 1'b1, JUNK, E(T_FAULT, 1'b1, 0, 2'b01));
        cyc("to_reset", 1'b1, 1'b1, JUNK, E(T_RESET, 1'b1, 0, 2'b00));

        // Illegal opcode in DECODE.
        fetch_decode("ill", 6'h3F);
        cyc("ill_fault", 1'b1, 1'b1, 6'h00, E(T_FAULT, 1'b1, 0, 2'b10));
        cyc("ill_rst_edge", 1'b0, 1'b1, JUNK, E(T_FAULT, 1'b1, 0, 2'b10));
        cyc("ill_reset", 1'b1, 1'b1, JUNK, E(T_RESET, 1'b1, 0, 2'b00));

        // Reset during a stalled store: no write strobe on the following cycle.
        fetch_decode("swrst", 6'h2B);
        cyc("swrst_memaddr", 1'b1, 1'b1, JUNK, E(T_MEMADDR, 1'b1, 0, 2'b00));
        cyc("swrst_memwr_wait", 1'b0, 1'b0, JUNK, E(T_MEMWR, 1'b0, 0, 2'b00));
        cyc("swrst_reset", 1'b1, 1'b1, JUNK, E(T_RESET, 1'b1, 0, 2'b00));
        cyc("swrst_fetch", 1'b1, 1'b0, JUNK, E(T_FETCH, 1'b0, 0, 2'b00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control FSM that replaces the single-cycle opcode decoder for the shared-memory MIPS datapath. Each instruction takes 3–5 states plus memory wait states, so one ALU and one memory port serve the whole datapath. A `mem_ready` handshake supports variable-latency memory, and a bounded wait timer detects hung accesses. It sits between the instruction register's opcode field and every datapath mux and enable.

## Interface
**Parameters**
- `ALUOP_W`, default 3: width of `alu_op`; must be ≥ 3.
- `MEM_TIMEOUT`, default 15: maximum wait cycles per memory access; 0 disables the timeout.

**Ports**
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `opcode` input 6: IR[31:26]; sampled only in DECODE.
- `mem_ready` input 1: memory completes the current access this cycle.
- `pc_write`, `pc_write_cond`, `ior_d`, `ir_write` output 1 each: PC enable, branch-qualified PC enable, address-mux select, IR enable.
- `mem_read`, `mem_write` output 1 each: memory request strobes.
- `mem_to_reg`, `reg_dst`, `reg_write` output 1 each: register-file writeback controls.
- `alu_src_a` output 1: 0 = PC, 1 = A.
- `alu_src_b` output 2: 0 = B, 1 = constant 4, 2 = extended imm, 3 = sign-extended imm<<2.
- `pc_source` output 2: 0 = ALU result, 1 = ALUOut.
- `alu_op` output `ALUOP_W`: 0 add, 1 sub, 2 funct, 3 addi, 4 and, 5 or.
- `load_half`, `load_half_unsigned` output 1 each: halfword extraction select for lh and lhu.
- `retire` output 1: one-cycle pulse in the final state of each instruction.
- `illegal_op`, `mem_timeout` output 1 each: sticky fault flags.

## Operation
**States:** RESET, FETCH, DECODE, MEMADDR, MEMRD, MEMWB, MEMWR, REXEC, RWB, IEXEC, IWB, BRANCH, FAULT.

**Transitions**
- RESET→FETCH unconditionally.
- FETCH→DECODE on `mem_ready`; otherwise FETCH holds.
- DECODE dispatches on `opcode`:
  - 0x00 → REXEC.
  - 0x23, 0x21, 0x25, 0x2B → MEMADDR.
  - 0x08, 0x0C, 0x0D → IEXEC.
  - 0x04 → BRANCH.
  - any other opcode → FAULT with `illegal_op`=1.
- MEMADDR→MEMRD for loads, →MEMWR for sw.
- MEMRD→MEMWB on `mem_ready`.
- MEMWR→FETCH on `mem_ready`.
- REXEC→RWB, IEXEC→IWB.
- RWB, IWB, MEMWB, BRANCH → FETCH.
- FAULT is absorbing; only reset leaves it.

**Opcode register:** the opcode class is latched in DECODE. MEMADDR through MEMWB use that latched copy, never the live `opcode` input.

**Outputs per state** (all unlisted outputs are 0)
- FETCH: `mem_read`=1, `alu_src_b`=1, `alu_op`=0. `ir_write` and `pc_write` are asserted only while `mem_ready`=1 (Mealy qualification).
- DECODE: `alu_src_b`=3, `alu_op`=0.
- MEMADDR: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=0.
- MEMRD: `mem_read`=1, `ior_d`=1.
- MEMWR: `mem_write`=1, `ior_d`=1.
- MEMWB: `reg_write`=1, `mem_to_reg`=1. `load_half` is 1 for lh, `load_half_unsigned` is 1 for lhu.
- REXEC: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=2.
- RWB: `reg_write`=1, `reg_dst`=1.
- IEXEC: `alu_src_a`=1, `alu_src_b`=2, `alu_op` = 3 for addi, 4 for andi, 5 for ori.
- IWB: `reg_write`=1.
- BRANCH: `alu_src_a`=1, `alu_op`=1, `pc_write_cond`=1, `pc_source`=1.

**Wait timer**
- Counts consecutive cycles in a memory state (FETCH, MEMRD, MEMWR) with `mem_ready`=0.
- Clears whenever the FSM enters or leaves a memory state.
- When the count reaches `MEM_TIMEOUT`, the FSM goes to FAULT and sets `mem_timeout`=1.
- `mem_ready` arriving in the same cycle as the limit wins: the access completes and no fault is raised.

**Retire:** `retire`=1 in RWB, IWB, MEMWB, BRANCH, and in the completing cycle of MEMWR.

## Timing
- Reset:
  - `rst_n`=0 sampled at an edge puts the FSM in RESET.
  - Every output is 0 in RESET and both fault flags are cleared.
  - This applies mid-instruction too: a reset in any state, including a memory wait, abandons the access with no write strobe on the following cycle.
- Output timing: outputs are decoded combinationally from the state register. The only Mealy terms are `pc_write`, `ir_write` and the MEMWR `retire`, each gated by `mem_ready`.
- Cycles per instruction with zero-wait memory (`mem_ready` tied 1), counted from the FETCH entry cycle:
  - beq: 3.
  - R-type, I-type ALU, sw: 4.
  - lw, lh, lhu: 5.
- Each memory wait cycle adds exactly 1 cycle.
- `mem_read` and `mem_write` stay asserted, with an unchanged `ior_d`, until `mem_ready`. They are never asserted together.
- The fault flags are registered: they assert on the edge entering FAULT and hold until reset.

## Structure
- Package `mc_ctrl_pkg` holds:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_LH, OP_LHU, OP_ANDI, OP_ORI, OP_BEQ);
  - the state enum;
  - the `alu_op` codes;
  - the `alu_src_b` and `pc_source` codes.
- One sub-module, `mem_wait_timer`, parametrised by `MEM_TIMEOUT`. Inputs: `clk`, `rst_n`, `in_mem_state`, `mem_ready`. Output: `expired`.

## Test plan
- Reset, then R-type with `mem_ready`=1: states RESET, FETCH, DECODE, REXEC, RWB.
  - `alu_op`=2 in REXEC; `reg_write`=`reg_dst`=1 in RWB.
  - `retire` pulses in cycle 4 after FETCH entry.
- Back-to-back lw, lh, lhu, sw, beq, andi, ori, addi with zero-wait memory:
  - cycle counts are 5, 5, 5, 4, 3, 4, 4, 4;
  - `load_half` and `load_half_unsigned` assert only in MEMWB of lh and lhu respectively;
  - IEXEC `alu_op` is 4 for andi, 5 for ori, 3 for addi.
- lw with `mem_ready` low for 3 cycles in MEMRD:
  - the FSM holds MEMRD with `mem_read`=`ior_d`=1;
  - instruction total is 8 cycles and there is no fault.
- `MEM_TIMEOUT`=4 with `mem_ready` stuck 0 in FETCH: FAULT after 4 wait cycles, `mem_timeout`=1 sticky, all strobes 0.
- `MEM_TIMEOUT`=4 with `mem_ready` rising in the 4th wait cycle: the fetch completes, no fault.
- Opcode 0x3F in DECODE: FAULT, `illegal_op`=1.
  - `rst_n`=0 for one edge clears both flags and returns the FSM to RESET then FETCH.
  - A reset mid-MEMWR leaves `mem_write`=0 on the next cycle.
